// File: rtl/op_seq_pkg.sv
// ============================================================================
// Module : op_seq_pkg
// Brief  : Shared state, operation and error-code definitions for op_sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package op_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        HOLD   = 3'd3,
        ERR    = 3'd4
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    localparam logic [7:0] ERR_DIVZERO = 8'hFF;
    localparam logic [7:0] ERR_TIMEOUT = 8'hEE;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Brief  : 2-flop synchroniser, tick-sampled debouncer and press-edge detector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_n,
    output logic stable,
    output logic press
);

    localparam int              c_CW     = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [c_CW-1:0] c_TARGET = c_CW'(DEBOUNCE_SAMPLES);
    localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);

    logic [1:0]      r_sync;
    logic            r_cand;
    logic [c_CW-1:0] r_cnt;
    logic            r_stable;
    logic            r_stable_d;
    logic [c_CW-1:0] w_cnt_nx;

    // Run length of equal samples, saturating once the level is accepted
    always_comb begin
        w_cnt_nx = c_ONE;
        if (r_sync[1] == r_cand) begin
            w_cnt_nx = (r_cnt == c_TARGET) ? r_cnt : r_cnt + c_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync     <= 2'b11;
            r_cand     <= 1'b1;
            r_cnt      <= c_TARGET;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
        end else begin
            r_sync     <= {r_sync[0], btn_n};
            r_stable_d <= r_stable;
            if (tick) begin
                r_cand <= r_sync[1];
                r_cnt  <= w_cnt_nx;
                if (w_cnt_nx == c_TARGET) begin
                    r_stable <= r_sync[1];
                end
            end
        end
    end

    assign stable = r_stable;
    assign press  = r_stable_d & ~r_stable;

endmodule

`default_nettype wire

// File: rtl/op_sequencer.sv
// ============================================================================
// Module : op_sequencer
// Brief  : Button-started multiply/divide sequencer with held result/status.
//          Optional WAIT timeout built when OP_SEQ_TIMEOUT_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module op_sequencer
    import op_seq_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int TIMEOUT_CYCLES   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_n,
    input  logic [7:0] sw,
    input  logic       op_sel,
    input  logic       mul_done,
    input  logic [7:0] mul_res,
    input  logic       div_done,
    input  logic [7:0] div_res,
    output logic       mul_init,
    output logic       div_init,
    output logic [7:0] opnd,
    output logic [7:0] result,
    output logic       busy,
    output logic       done,
    output logic       err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_bad
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t     r_state, w_state_nx;
    op_t        r_op, w_op_nx;
    logic [7:0] r_opnd, w_opnd_nx;
    logic [7:0] r_result, w_result_nx;
    logic       r_mul_init, r_div_init, r_busy, r_done, r_err;
    logic       w_btn_stable, w_press, w_req;
    logic       w_unit_done, w_timeout;
    logic [7:0] w_unit_res;

    btn_debounce #(
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_btn (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .btn_n  (btn_n),
        .stable (w_btn_stable),
        .press  (w_press)
    );

    // A press always coincides with the stable level having just gone low
    assign w_req       = w_press & ~w_btn_stable;
    assign w_unit_done = (r_op == OP_DIV) ? div_done : mul_done;
    assign w_unit_res  = (r_op == OP_DIV) ? div_res  : mul_res;

`ifdef OP_SEQ_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wait_cnt, w_wait_cnt_nx;

    assign w_timeout = (r_wait_cnt == c_TIMEOUT_LAST);

    always_comb begin
        w_wait_cnt_nx = r_wait_cnt;
        if (r_state == LAUNCH) begin
            w_wait_cnt_nx = '0;
        end else if (r_state == WAIT) begin
            w_wait_cnt_nx = r_wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nx;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nx  = r_state;
        w_op_nx     = r_op;
        w_opnd_nx   = r_opnd;
        w_result_nx = r_result;
        case (r_state)
            IDLE, HOLD, ERR: begin
                if (w_req) begin
                    w_opnd_nx = sw;
                    w_op_nx   = op_t'(op_sel);
                    if (op_t'(op_sel) == OP_DIV && sw[7:4] == 4'd0) begin
                        w_state_nx  = ERR;
                        w_result_nx = ERR_DIVZERO;
                    end else begin
                        w_state_nx = LAUNCH;
                    end
                end
            end
            // Any done level during LAUNCH is deliberately not looked at
            LAUNCH: w_state_nx = WAIT;
            WAIT: begin
                if (w_unit_done) begin
                    w_state_nx  = HOLD;
                    w_result_nx = w_unit_res;
                end else if (w_timeout) begin
                    w_state_nx  = ERR;
                    w_result_nx = ERR_TIMEOUT;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= OP_MUL;
            r_opnd     <= '0;
            r_result   <= '0;
            r_mul_init <= 1'b0;
            r_div_init <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_op       <= w_op_nx;
            r_opnd     <= w_opnd_nx;
            r_result   <= w_result_nx;
            r_mul_init <= (w_state_nx == LAUNCH) && (w_op_nx == OP_MUL);
            r_div_init <= (w_state_nx == LAUNCH) && (w_op_nx == OP_DIV);
            r_busy     <= (w_state_nx == LAUNCH) || (w_state_nx == WAIT);
            r_done     <= (w_state_nx == HOLD);
            r_err      <= (w_state_nx == ERR);
        end
    end

    assign mul_init = r_mul_init;
    assign div_init = r_div_init;
    assign opnd     = r_opnd;
    assign result   = r_result;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

`default_nettype wire
